move_scheduler: RTL and testbench

Per-game-tick movement sequencer for Pac-Man and the ghosts. On each `tick` it walks the sprites in index order and uses the single shared wall-lookup port (the `Map` block) to test each sprite's proposed 8-pixel step. Clear moves are committed; blocked moves fall back to the sprite's current heading or hold position. It owns all sprite position and heading registers and feeds the renderer and the ghost/score logic.

---
 rtl/pac_pkg.sv | 29 ++
 rtl/next_tile_calc.sv | 44 ++++
 rtl/move_scheduler.sv | 242 ++++++++++++++++++++++++
 tb/tb_move_scheduler.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pac_pkg.sv
// Shared definitions for the Pac-Man movement logic.
// Contents:
//   DIR_*       2-bit heading encoding (00 up, 01 down, 10 left, 11 right)
//   X_W, Y_W    coordinate widths (x wraps at X_MAX, y wraps modulo 512)
//   STEP_DEF    default pixels per committed step
//   X_MAX_DEF   default horizontal wrap modulus
//   state_e     move_scheduler FSM states
package pac_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam int X_W       = 10;
    localparam int Y_W       = 9;
    localparam int STEP_DEF  = 8;
    localparam int X_MAX_DEF = 640;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_REQ_CHK,
        S_CUR,
        S_CUR_CHK,
        S_DONE
    } state_e;

endpackage

// File: rtl/next_tile_calc.sv
// Combinational one-step target calculator.
// Ports:
//   x, y   current sprite position
//   dir    heading to evaluate
//   tx, ty position one STEP away in that heading; x wraps at X_MAX,
//          y wraps naturally modulo 2**Y_W. No clamping is done here,
//          edge walls come from the map.
module next_tile_calc
    import pac_pkg::*;
#(
    parameter int STEP  = STEP_DEF,
    parameter int X_MAX = X_MAX_DEF
) (
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    input  logic [1:0]     dir,
    output logic [X_W-1:0] tx,
    output logic [Y_W-1:0] ty
);

    localparam int XE = X_W + 1;

    // One extra bit so x+STEP near X_MAX cannot overflow before the compare.
    logic [XE-1:0] x_plus;

    always_comb begin
        tx     = x;
        ty     = y;
        x_plus = {1'b0, x} + XE'(STEP);
        case (dir)
            DIR_UP:   ty = y - Y_W'(STEP);
            DIR_DOWN: ty = y + Y_W'(STEP);
            DIR_LEFT: begin
                if (x < X_W'(STEP)) tx = X_W'({1'b0, x} + XE'(X_MAX - STEP));
                else                tx = x - X_W'(STEP);
            end
            default: begin
                if (x_plus >= XE'(X_MAX)) tx = X_W'(x_plus - XE'(X_MAX));
                else                      tx = x_plus[X_W-1:0];
            end
        endcase
    end

endmodule

// File: rtl/move_scheduler.sv
// Per-game-tick movement sequencer. On an accepted tick it walks the active
// sprites in index order, probing the shared wall map with each sprite's
// requested step and, if that is walled and differs from the current
// heading, with the current-heading step.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   tick                starts a round (accepted only in IDLE)
//   active, dir_req     per-sprite enable and requested heading, snapshotted at tick
//   map_x, map_y        registered wall-lookup address
//   map_is_wall         lookup result, valid the cycle after the address
//   pos_x, pos_y        packed sprite positions
//   cur_dir             packed committed headings
//   blocked             sprite held in place during its last move
//   busy, done          round in progress / one-cycle round end
//   tick_miss           one-cycle pulse for a tick dropped while busy
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for tick
// S_REQ     | map address holds target of requested heading
// S_REQ_CHK | map result for requested heading is valid
// S_CUR     | map address holds target of current heading (fallback)
// S_CUR_CHK | map result for current heading is valid
// S_DONE    | done pulse, back to idle
module move_scheduler
    import pac_pkg::*;
#(
    parameter int N_SPR  = 5,
    parameter int STEP   = STEP_DEF,
    parameter int X_MAX  = X_MAX_DEF,
    parameter int PAC_X0 = 320,
    parameter int PAC_Y0 = 360,
    parameter int GH_X0  = 320,
    parameter int GH_Y0  = 232
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic [N_SPR-1:0]       active,
    input  logic [2*N_SPR-1:0]     dir_req,
    output logic [X_W-1:0]         map_x,
    output logic [Y_W-1:0]         map_y,
    input  logic                   map_is_wall,
    output logic [X_W*N_SPR-1:0]   pos_x,
    output logic [Y_W*N_SPR-1:0]   pos_y,
    output logic [2*N_SPR-1:0]     cur_dir,
    output logic [N_SPR-1:0]       blocked,
    output logic                   busy,
    output logic                   done,
    output logic                   tick_miss
);

    localparam int IDX_W = (N_SPR > 1) ? $clog2(N_SPR) : 1;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [N_SPR-1:0]       act_snap_q, act_snap_d;
    logic [2*N_SPR-1:0]     dir_snap_q, dir_snap_d;
    logic [X_W*N_SPR-1:0]   pos_x_q, pos_x_d;
    logic [Y_W*N_SPR-1:0]   pos_y_q, pos_y_d;
    logic [2*N_SPR-1:0]     cur_dir_q, cur_dir_d;
    logic [N_SPR-1:0]       blocked_q, blocked_d;
    logic [X_W-1:0]         map_x_q, map_x_d;
    logic [Y_W-1:0]         map_y_q, map_y_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   tick_miss_q, tick_miss_d;

    // Next active sprite: from the live inputs in IDLE, otherwise the
    // lowest snapshotted sprite above the current index.
    logic [N_SPR-1:0]       search_mask;
    logic                   nxt_found;
    logic [IDX_W-1:0]       nxt_idx;

    always_comb begin
        search_mask = '0;
        for (int j = 0; j < N_SPR; j++) begin
            if (state_q == S_IDLE) search_mask[j] = active[j];
            else                   search_mask[j] = act_snap_q[j] && (j > int'(idx_q));
        end
        nxt_found = 1'b0;
        nxt_idx   = '0;
        for (int j = N_SPR - 1; j >= 0; j--) begin
            if (search_mask[j]) begin
                nxt_found = 1'b1;
                nxt_idx   = IDX_W'(j);
            end
        end
    end

    // The single calculator is fed whatever the next map address must be:
    // the current-heading step on a fallback, else the next sprite's request.
    logic                   req_same;
    logic                   use_cur;
    logic [IDX_W-1:0]       calc_idx;
    logic [1:0]             calc_dir;
    logic [X_W-1:0]         calc_x, tgt_x;
    logic [Y_W-1:0]         calc_y, tgt_y;

    always_comb begin
        req_same = (dir_snap_q[2*idx_q +: 2] == cur_dir_q[2*idx_q +: 2]);
        use_cur  = (state_q == S_REQ_CHK) && map_is_wall && !req_same;
        calc_idx = use_cur ? idx_q : nxt_idx;
        if (use_cur)                calc_dir = cur_dir_q[2*calc_idx +: 2];
        else if (state_q == S_IDLE) calc_dir = dir_req[2*calc_idx +: 2];
        else                        calc_dir = dir_snap_q[2*calc_idx +: 2];
        calc_x = pos_x_q[X_W*calc_idx +: X_W];
        calc_y = pos_y_q[Y_W*calc_idx +: Y_W];
    end

    next_tile_calc #(.STEP(STEP), .X_MAX(X_MAX)) u_calc (
        .x   (calc_x),
        .y   (calc_y),
        .dir (calc_dir),
        .tx  (tgt_x),
        .ty  (tgt_y)
    );

    logic advance;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        act_snap_d  = act_snap_q;
        dir_snap_d  = dir_snap_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        cur_dir_d   = cur_dir_q;
        blocked_d   = blocked_q;
        map_x_d     = map_x_q;
        map_y_d     = map_y_q;
        advance     = 1'b0;
        tick_miss_d = tick && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    act_snap_d = active;
                    dir_snap_d = dir_req;
                    if (nxt_found) begin
                        idx_d   = nxt_idx;
                        map_x_d = tgt_x;
                        map_y_d = tgt_y;
                        state_d = S_REQ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_REQ: state_d = S_REQ_CHK;
            S_REQ_CHK: begin
                // The registered address is the target, so commit from it.
                if (!map_is_wall) begin
                    pos_x_d[X_W*idx_q +: X_W] = map_x_q;
                    pos_y_d[Y_W*idx_q +: Y_W] = map_y_q;
                    cur_dir_d[2*idx_q +: 2]   = dir_snap_q[2*idx_q +: 2];
                    blocked_d[idx_q]          = 1'b0;
                    advance                   = 1'b1;
                end else if (req_same) begin
                    blocked_d[idx_q] = 1'b1;
                    advance          = 1'b1;
                end else begin
                    map_x_d = tgt_x;
                    map_y_d = tgt_y;
                    state_d = S_CUR;
                end
            end
            S_CUR: state_d = S_CUR_CHK;
            S_CUR_CHK: begin
                if (!map_is_wall) begin
                    pos_x_d[X_W*idx_q +: X_W] = map_x_q;
                    pos_y_d[Y_W*idx_q +: Y_W] = map_y_q;
                    blocked_d[idx_q]          = 1'b0;
                end else begin
                    blocked_d[idx_q] = 1'b1;
                end
                advance = 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (nxt_found) begin
                idx_d   = nxt_idx;
                map_x_d = tgt_x;
                map_y_d = tgt_y;
                state_d = S_REQ;
            end else begin
                state_d = S_DONE;
            end
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            act_snap_q  <= '0;
            dir_snap_q  <= '0;
            blocked_q   <= '0;
            map_x_q     <= '0;
            map_y_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tick_miss_q <= 1'b0;
            for (int k = 0; k < N_SPR; k++) begin
                pos_x_q[X_W*k +: X_W] <= (k == 0) ? X_W'(PAC_X0) : X_W'(GH_X0);
                pos_y_q[Y_W*k +: Y_W] <= (k == 0) ? Y_W'(PAC_Y0) : Y_W'(GH_Y0);
                cur_dir_q[2*k +: 2]   <= DIR_LEFT;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            act_snap_q  <= act_snap_d;
            dir_snap_q  <= dir_snap_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            cur_dir_q   <= cur_dir_d;
            blocked_q   <= blocked_d;
            map_x_q     <= map_x_d;
            map_y_q     <= map_y_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tick_miss_q <= tick_miss_d;
        end
    end

    assign map_x     = map_x_q;
    assign map_y     = map_y_q;
    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
    assign cur_dir   = cur_dir_q;
    assign blocked   = blocked_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign tick_miss = tick_miss_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler with a registered wall-map model.
module tb_move_scheduler;

    logic        clk = 1'b0;
    logic        rst, tick, tick_w;
    logic [4:0]  active;
    logic [9:0]  dir_req, dir_w;
    logic [9:0]  map_x, map_x_w;
    logic [8:0]  map_y, map_y_w;
    logic        map_is_wall = 1'b0;
    logic [49:0] pos_x, pos_x_w;
    logic [44:0] pos_y, pos_y_w;
    logic [9:0]  cur_dir, cur_dir_w;
    logic [4:0]  blocked, blocked_w;
    logic        busy, done, tick_miss;
    logic        busy_w, done_w, tick_miss_w;

    // Wall map: up to two walled tiles, result registered one cycle after address.
    logic        w0_en, w1_en;
    logic [9:0]  w0_x, w1_x;
    logic [8:0]  w0_y, w1_y;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    always @(posedge clk)
        map_is_wall <= (w0_en && map_x == w0_x && map_y == w0_y) ||
                       (w1_en && map_x == w1_x && map_y == w1_y);

    move_scheduler dut (
        .clk(clk), .rst(rst), .tick(tick), .active(active), .dir_req(dir_req),
        .map_x(map_x), .map_y(map_y), .map_is_wall(map_is_wall),
        .pos_x(pos_x), .pos_y(pos_y), .cur_dir(cur_dir), .blocked(blocked),
        .busy(busy), .done(done), .tick_miss(tick_miss)
    );

    // Second instance starting Pac-Man at x=4 for the off-grid wrap cases.
    move_scheduler #(.PAC_X0(4)) dut_wrap (
        .clk(clk), .rst(rst), .tick(tick_w), .active(5'b00001), .dir_req(dir_w),
        .map_x(map_x_w), .map_y(map_y_w), .map_is_wall(1'b0),
        .pos_x(pos_x_w), .pos_y(pos_y_w), .cur_dir(cur_dir_w), .blocked(blocked_w),
        .busy(busy_w), .done(done_w), .tick_miss(tick_miss_w)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Pulse tick, then wait for done; cyc = cycles from tick to done.
    task automatic run_round(output int cyc);
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    localparam logic [49:0] POSX_RST = {5{10'd320}};
    localparam logic [44:0] POSY_RST = {9'd232, 9'd232, 9'd232, 9'd232, 9'd360};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int done_at, miss_at, n_done, n_miss;
        logic busy12;

        rst = 1'b1; tick = 1'b0; tick_w = 1'b0;
        active = '0; dir_req = '0; dir_w = '0;
        w0_en = 1'b0; w1_en = 1'b0;
        w0_x = '0; w0_y = '0; w1_x = '0; w1_y = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_pos_x", pos_x, POSX_RST);
        check("rst_pos_y", pos_y, POSY_RST);
        check("rst_cur_dir", cur_dir, 10'b1010101010);
        check("rst_blocked", blocked, 5'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_tick_miss", tick_miss, 1'b0);
        check("rst_map_x", map_x, 10'd0);
        check("rst_map_y", map_y, 9'd0);
        check("rst_wrap_x", pos_x_w[9:0], 10'd4);

        // No active sprite: straight to DONE.
        run_round(cyc);
        check("none_done_cyc", cyc, 1);
        @(negedge clk);
        check("none_idle", busy, 1'b0);

        // Pac-Man alone steps right.
        active = 5'b00001; dir_req = 10'b0000000011;
        run_round(cyc);
        check("one_done_cyc", cyc, 3);
        check("one_x", pos_x[9:0], 10'd328);
        check("one_y", pos_y[8:0], 9'd360);
        check("one_dir", cur_dir[1:0], 2'b11);
        check("one_blocked", blocked[0], 1'b0);
        @(negedge clk);
        check("one_done_pulse", done, 1'b0);
        check("one_idle", busy, 1'b0);

        // Back to (320,360) heading left.
        dir_req = 10'b0000000010;
        run_round(cyc);
        check("left_x", pos_x[9:0], 10'd320);
        check("left_dir", cur_dir[1:0], 2'b10);

        // Request up walled, current (left) clear: fallback commit.
        w0_en = 1'b1; w0_x = 10'd320; w0_y = 9'd352;
        dir_req = 10'b0000000000;
        run_round(cyc);
        check("fb_done_cyc", cyc, 5);
        check("fb_x", pos_x[9:0], 10'd312);
        check("fb_y", pos_y[8:0], 9'd360);
        check("fb_dir", cur_dir[1:0], 2'b10);
        check("fb_blocked", blocked[0], 1'b0);

        // Both walled: hold.
        w0_x = 10'd312; w0_y = 9'd352;
        w1_en = 1'b1; w1_x = 10'd304; w1_y = 9'd360;
        run_round(cyc);
        check("both_done_cyc", cyc, 5);
        check("both_x", pos_x[9:0], 10'd312);
        check("both_blocked", blocked[0], 1'b1);
        check("both_dir", cur_dir[1:0], 2'b10);

        // Request equals current heading and is walled: short round.
        w0_en = 1'b0;
        dir_req = 10'b0000000010;
        run_round(cyc);
        check("same_done_cyc", cyc, 3);
        check("same_x", pos_x[9:0], 10'd312);
        check("same_blocked", blocked[0], 1'b1);

        // Wall removed: move clears blocked.
        w1_en = 1'b0;
        run_round(cyc);
        check("clr_x", pos_x[9:0], 10'd304);
        check("clr_blocked", blocked[0], 1'b0);

        // Walk left to x=0, then wrap both ways.
        repeat (38) run_round(cyc);
        check("walk_x", pos_x[9:0], 10'd0);
        run_round(cyc);
        check("wrap_left_x", pos_x[9:0], 10'd632);
        dir_req = 10'b0000000011;
        run_round(cyc);
        check("wrap_right_x", pos_x[9:0], 10'd0);
        check("wrap_right_dir", cur_dir[1:0], 2'b11);

        // Off-grid wrap on the second instance.
        dir_w = 10'b0000000010;
        @(negedge clk); tick_w = 1'b1;
        @(negedge clk); tick_w = 1'b0;
        repeat (4) @(negedge clk);
        check("wrap4_left_x", pos_x_w[9:0], 10'd636);
        dir_w = 10'b0000000011;
        @(negedge clk); tick_w = 1'b1;
        @(negedge clk); tick_w = 1'b0;
        repeat (4) @(negedge clk);
        check("wrap636_right_x", pos_x_w[9:0], 10'd4);

        // All five sprites, clear map, second tick dropped at t+5.
        active = 5'b11111;
        dir_req = 10'b11_10_01_00_11;
        done_at = 0; miss_at = 0; n_done = 0; n_miss = 0; busy12 = 1'bx;
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            if (k > 1) @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                if (done_at == 0) done_at = k;
            end
            if (tick_miss === 1'b1) begin
                n_miss++;
                if (miss_at == 0) miss_at = k;
            end
            if (k == 12) busy12 = busy;
            if (k == 5) tick = 1'b1;
            if (k == 6) tick = 1'b0;
        end
        check("all_done_at", done_at, 11);
        check("all_done_count", n_done, 1);
        check("all_miss_at", miss_at, 6);
        check("all_miss_count", n_miss, 1);
        check("all_idle_t12", busy12, 1'b0);
        check("all_pos_x", pos_x, {10'd328, 10'd312, 10'd320, 10'd320, 10'd8});
        check("all_pos_y", pos_y, {9'd232, 9'd232, 9'd240, 9'd224, 9'd360});
        check("all_cur_dir", cur_dir, 10'b11_10_01_00_11);
        check("all_blocked", blocked, 5'b0);

        // Reset mid-round at t+4, then a tick coincident with reset.
        dir_req = 10'b00_00_00_00_00;
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_pos_x", pos_x, POSX_RST);
        check("mid_rst_pos_y", pos_y, POSY_RST);
        check("mid_rst_cur_dir", cur_dir, 10'b1010101010);
        check("mid_rst_done", done, 1'b0);
        tick = 1'b1;
        @(negedge clk);
        rst = 1'b0; tick = 1'b0;
        check("rst_tick_busy", busy, 1'b0);
        @(negedge clk);
        check("rst_tick_idle", busy, 1'b0);
        check("rst_tick_miss", tick_miss, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
